// File: rtl/omsp_led_scroll_pkg.sv
// omsp_led_scroll_pkg: shared register map, bit indices and constants
// for the LED marquee peripheral (role of omsp_led_defines).
package omsp_led_scroll_pkg;

  typedef enum logic [1:0] {
    REG_CTRL = 2'd0,
    REG_RATE = 2'd1,
    REG_DATA = 2'd2,
    REG_STAT = 2'd3
  } reg_e;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_HEX   = 1;
  localparam int CTRL_CLR   = 2;
  localparam int CTRL_BLINK = 3;

  localparam int STAT_FULL  = 8;
  localparam int STAT_EMPTY = 9;
  localparam int STAT_OVF   = 10;

  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/omsp_led_scroll_seg7_dec.sv
// omsp_seg7_dec: nibble to 7-segment pattern, a=bit0 .. g=bit6.
// Purely combinational, used on the DATA write path.
module omsp_seg7_dec
  import omsp_led_scroll_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // hex glyph lookup
  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
  end

endmodule

// File: rtl/omsp_led_scroll.sv
// omsp_led_scroll: 16-entry character buffer with 8-digit scrolling window.
// Optional blink support is built when LED_SCROLL_BLINK_EN is defined.
module omsp_led_scroll
  import omsp_led_scroll_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR = 15'h00A0,
  parameter int          DEC_WD    = 3,
  parameter int          DEPTH     = 16,
  parameter int          PRE_WD    = 8
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  output logic [63:0] disp,
  output logic        disp_upd
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic              reg_sel, reg_wr, reg_rd;
  reg_e              reg_ofs;
  logic              ctrl_wr, data_wr, stat_w1c, clr;
  logic              en, hex, ovf, full, empty;
  logic [15:0]       rate;
  logic [CW-1:0]     count, cnt_nxt, win, win_lim, idx;
  logic [PRE_WD-1:0] pre_cnt;
  logic [15:0]       step_cnt;
  logic              tick, append, ovf_set, upd_pend;
  logic [6:0]        seg_code, code;
  logic [6:0]        buf_mem [DEPTH];
  logic [63:0]       img;
  logic              blink, phase;

  assign reg_sel = per_en &
    (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
  assign reg_ofs = reg_e'(per_addr[1:0]);
  assign reg_wr  = reg_sel & (|per_we);
  assign reg_rd  = reg_sel & ~(|per_we);

  assign ctrl_wr  = reg_wr & (reg_ofs == REG_CTRL) & per_we[0];
  assign data_wr  = reg_wr & (reg_ofs == REG_DATA) & per_we[0];
  assign stat_w1c = reg_wr & (reg_ofs == REG_STAT) & per_we[1]
                  & per_din[STAT_OVF];
  assign clr      = ctrl_wr & per_din[CTRL_CLR];

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign append  = data_wr & ~clr & ~full;
  assign ovf_set = data_wr & ~clr & full;
  assign cnt_nxt = count + CW'(append);
  assign win_lim = cnt_nxt - CW'(8);
  assign tick    = en & (&pre_cnt) & (step_cnt == rate);

  omsp_seg7_dec u_dec (
    .nib (per_din[3:0]),
    .seg (seg_code)
  );

  assign code = hex ? seg_code : per_din[6:0];

  // control and rate registers, sticky overflow flag
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      en   <= 1'b0;
      hex  <= 1'b0;
      rate <= 16'h0000;
      ovf  <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        en  <= per_din[CTRL_EN];
        hex <= per_din[CTRL_HEX];
      end
      if (reg_wr && reg_ofs == REG_RATE) begin
        if (per_we[0]) rate[7:0]  <= per_din[7:0];
        if (per_we[1]) rate[15:8] <= per_din[15:8];
      end
      ovf <= (ovf & ~stat_w1c) | ovf_set;
    end
  end

  // character buffer storage
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      for (int i = 0; i < DEPTH; i++) buf_mem[i] <= SEG_BLANK;
    end else if (append) begin
      buf_mem[count[AW-1:0]] <= code;
    end
  end

  // prescaler and rate divider producing the scroll tick
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      pre_cnt  <= '0;
      step_cnt <= '0;
    end else if (!en) begin
      pre_cnt  <= '0;
      step_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_WD'(1);
      if (&pre_cnt) step_cnt <= tick ? 16'h0000 : step_cnt + 16'h0001;
    end
  end

  // fill level and window position; step sees post-append count
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      count <= '0;
      win   <= '0;
    end else if (clr) begin
      count <= '0;
      win   <= '0;
    end else begin
      count <= cnt_nxt;
      if (tick && cnt_nxt > CW'(8))
        win <= (win == win_lim) ? '0 : win + CW'(1);
    end
  end

`ifdef LED_SCROLL_BLINK_EN
  // blink enable and phase, phase flips on every tick
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      blink <= 1'b0;
      phase <= 1'b0;
    end else begin
      if (ctrl_wr) blink <= per_din[CTRL_BLINK];
      phase <= blink & (phase ^ tick);
    end
  end
`else
  assign blink = 1'b0;
  assign phase = 1'b0;
`endif

  // 8-digit image of the current window
  always_comb begin
    img = '0;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      idx = win + CW'(i);
      if (idx < count) img[8*i +: 7] = buf_mem[idx[AW-1:0]];
    end
    if (phase) img = '0;
  end

  // reload disp one cycle after any display-affecting event
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      upd_pend <= 1'b0;
      disp_upd <= 1'b0;
      disp     <= '0;
    end else begin
      upd_pend <= tick | append | clr | ctrl_wr;
      disp_upd <= upd_pend;
      if (upd_pend) disp <= img;
    end
  end

  // register read mux
  always_comb begin
    per_dout = 16'h0000;
    if (reg_rd) begin
      unique case (reg_ofs)
        REG_CTRL: begin
          per_dout[CTRL_EN]    = en;
          per_dout[CTRL_HEX]   = hex;
          per_dout[CTRL_BLINK] = blink;
        end
        REG_RATE: per_dout = rate;
        REG_DATA: per_dout = 16'h0000;
        REG_STAT: begin
          per_dout             = 16'(count);
          per_dout[STAT_FULL]  = full;
          per_dout[STAT_EMPTY] = empty;
          per_dout[STAT_OVF]   = ovf;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_omsp_led_scroll.sv
// tb_omsp_led_scroll: random bus traffic against a behavioural model
// of the LED scroll peripheral, plus fixed directed expectations.
module tb_omsp_led_scroll;

  logic        mclk = 1'b0;
  logic        puc_rst = 1'b1;
  logic [13:0] per_addr = '0;
  logic [15:0] per_din = '0;
  logic        per_en = 1'b0;
  logic [1:0]  per_we = '0;
  logic [15:0] per_dout;
  logic [63:0] disp;
  logic        disp_upd;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 mclk = ~mclk;

  omsp_led_scroll #(.PRE_WD(2)) dut (
    .mclk     (mclk),
    .puc_rst  (puc_rst),
    .per_addr (per_addr),
    .per_din  (per_din),
    .per_en   (per_en),
    .per_we   (per_we),
    .per_dout (per_dout),
    .disp     (disp),
    .disp_upd (disp_upd)
  );

  localparam logic [13:0] WBASE = 14'h0050;
  localparam logic [6:0] SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // behavioural model state
  bit          m_en, m_hex, m_blink, m_phase, m_ovf, m_pend, m_upd;
  logic [15:0] m_rate;
  int          m_count, m_win, m_ecnt;
  logic [6:0]  m_buf [16];
  logic [63:0] m_disp;

  function automatic logic [63:0] m_image();
    logic [63:0] r;
    r = '0;
    if (m_phase) return r;
    for (int i = 0; i < 8; i++)
      if (m_win + i < m_count) r[8*i +: 8] = {1'b0, m_buf[m_win + i]};
    return r;
  endfunction

  function automatic logic [15:0] m_read(input logic [1:0] o);
    logic [15:0] r;
    r = 16'h0;
    case (o)
      2'd0: r = {12'h0, m_blink, 1'b0, m_hex, m_en};
      2'd1: r = m_rate;
      2'd2: r = 16'h0;
      default: begin
        r = 16'(m_count);
        if (m_count == 16) r = r | 16'h0100;
        if (m_count == 0)  r = r | 16'h0200;
        if (m_ovf)         r = r | 16'h0400;
      end
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_en = 0; m_hex = 0; m_blink = 0; m_phase = 0; m_ovf = 0;
    m_pend = 0; m_upd = 0; m_rate = 0; m_count = 0; m_win = 0;
    m_ecnt = 0; m_disp = '0;
    for (int i = 0; i < 16; i++) m_buf[i] = 7'h00;
  endtask

  task automatic model_step();
    bit wr, cw, dw, clr, tick, full0, app;
    int p;
    wr  = per_en && per_we != 0 && per_addr[13:2] == WBASE[13:2];
    cw  = wr && per_addr[1:0] == 2'd0 && per_we[0];
    dw  = wr && per_addr[1:0] == 2'd2 && per_we[0];
    clr = cw && per_din[2];
    p = 4 * (int'(m_rate) + 1);
    tick  = m_en && (m_ecnt % p == p - 1);
    full0 = (m_count == 16);
    app   = dw && !clr && !full0;
    m_upd = m_pend;
    if (m_pend) m_disp = m_image();
    m_pend = tick || app || clr || cw;
    if (clr) begin
      m_count = 0;
      m_win = 0;
    end else begin
      if (app) begin
        m_buf[m_count] = m_hex ? SEG[per_din[3:0]] : per_din[6:0];
        m_count++;
      end
      if (tick && m_count > 8)
        m_win = (m_win == m_count - 8) ? 0 : m_win + 1;
    end
    if (wr && per_addr[1:0] == 2'd3 && per_we[1] && per_din[10]) m_ovf = 0;
    if (dw && !clr && full0) m_ovf = 1;
`ifdef LED_SCROLL_BLINK_EN
    m_phase = m_blink && (m_phase ^ tick);
    if (cw) m_blink = per_din[3];
`endif
    m_ecnt = m_en ? m_ecnt + 1 : 0;
    if (cw) begin
      m_en  = per_din[0];
      m_hex = per_din[1];
    end
    if (wr && per_addr[1:0] == 2'd1) begin
      if (per_we[0]) m_rate[7:0]  = per_din[7:0];
      if (per_we[1]) m_rate[15:8] = per_din[15:8];
    end
  endtask

  always @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) model_reset();
    else model_step();
  end

  always @(posedge mclk) cyc <= cyc + 1;

  // per-cycle compare of the display outputs
  always @(negedge mclk) begin
    if (!puc_rst) begin
      vectors++;
      if (disp !== m_disp || disp_upd !== m_upd) begin
        miscompares++;
        $display("FAIL disp cyc=%0d: got %h upd=%b, expected %h upd=%b",
                 cyc, disp, disp_upd, m_disp, m_upd);
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] o, input logic [15:0] d,
                    input logic [1:0] we);
    @(negedge mclk); #1;
    per_en = 1; per_addr = WBASE | 14'(o); per_we = we; per_din = d;
    @(posedge mclk); #1;
    per_en = 0; per_we = 0;
  endtask

  task automatic rd(input logic [13:0] a, output logic [15:0] act,
                    output logic [15:0] mod);
    @(negedge mclk); #1;
    per_en = 1; per_addr = a; per_we = 0;
    #1;
    act = per_dout;
    mod = (a[13:2] == WBASE[13:2]) ? m_read(a[1:0]) : 16'h0;
    @(posedge mclk); #1;
    per_en = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  logic [15:0] act, mod;
  logic [7:0]  d0 [4];
  int          t [4];
  int          n;

  initial begin
    repeat (3) @(posedge mclk);
    @(negedge mclk); #1;
    puc_rst = 0;
    idle(1);

    check("reset disp", disp, 64'h0);
    check("reset upd", 64'(disp_upd), 64'h0);
    rd(WBASE | 14'd3, act, mod);
    check("reset STAT", 64'(act), 64'h0200);
    rd(WBASE | 14'd0, act, mod);
    check("reset CTRL", 64'(act), 64'h0000);

    wr(2'd0, 16'h0003, 2'b01);
    wr(2'd2, 16'h0001, 2'b01);
    wr(2'd2, 16'h0002, 2'b01);
    wr(2'd2, 16'h0003, 2'b01);
    idle(3);
    check("hex 1,2,3 disp", disp, 64'h00000000004F5B06);
    rd(WBASE | 14'd3, act, mod);
    check("STAT after 3", 64'(act), 64'h0003);

    wr(2'd0, 16'h0006, 2'b01);
    for (int i = 0; i < 10; i++) wr(2'd2, 16'(i), 2'b01);
    wr(2'd1, 16'h0001, 2'b11);
    wr(2'd0, 16'h0003, 2'b01);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      @(negedge mclk);
      while (!disp_upd && n < 40) begin
        @(negedge mclk);
        n++;
      end
      if (!disp_upd) begin
        vectors++;
        miscompares++;
        $display("FAIL scroll wait: got no disp_upd in 40 cycles, expected pulse %0d", k);
      end
      d0[k] = disp[7:0];
      t[k] = cyc;
    end
    check("scroll d0[0]", 64'(d0[0]), 64'h3F);
    check("scroll d0[1]", 64'(d0[1]), 64'h06);
    check("scroll d0[2]", 64'(d0[2]), 64'h5B);
    check("scroll d0[3]", 64'(d0[3]), 64'h3F);
    check("tick period a", 64'(t[2] - t[1]), 64'd8);
    check("tick period b", 64'(t[3] - t[2]), 64'd8);

    wr(2'd0, 16'h0006, 2'b01);
    for (int i = 0; i < 17; i++) wr(2'd2, 16'(i), 2'b01);
    rd(WBASE | 14'd3, act, mod);
    check("STAT full ovf", 64'(act), 64'h0510);
    wr(2'd3, 16'h0400, 2'b10);
    rd(WBASE | 14'd3, act, mod);
    check("STAT ovf clr", 64'(act), 64'h0110);
    wr(2'd1, 16'hABCD, 2'b01);
    rd(WBASE | 14'd1, act, mod);
    check("RATE low byte", 64'(act), 64'h00CD);
    rd(WBASE | 14'd2, act, mod);
    check("DATA reads 0", 64'(act), 64'h0000);

    wr(2'd0, 16'h0006, 2'b01);
    idle(3);
    check("CLR disp", disp, 64'h0);
    rd(WBASE | 14'd3, act, mod);
    check("CLR STAT", 64'(act), 64'h0200);

    wr(2'd0, 16'h000B, 2'b01);
    rd(WBASE | 14'd0, act, mod);
`ifdef LED_SCROLL_BLINK_EN
    check("CTRL blink rd", 64'(act), 64'h000B);
`else
    check("CTRL blink rd", 64'(act), 64'h0003);
`endif
    wr(2'd0, 16'h0002, 2'b01);
    rd(14'h0060, act, mod);
    check("unselected rd", 64'(act), 64'h0000);
    wr(2'd1, 16'h0000, 2'b11);

    for (int i = 0; i < 1500; i++) begin
      int op;
      logic [15:0] d;
      op = $urandom_range(0, 99);
      d = 16'($urandom);
      if (i == 700) begin
        @(negedge mclk); #3;
        puc_rst = 1;
        #1;
        check("async rst disp", disp, 64'h0);
        check("async rst upd", 64'(disp_upd), 64'h0);
        check("async rst dout", 64'(per_dout), 64'h0);
        @(negedge mclk); #1;
        puc_rst = 0;
      end else if (op < 45) begin
        wr(2'd2, d, ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b01);
      end else if (op < 55) begin
        d = d & 16'h000B;
        if ($urandom_range(0, 7) == 0) d[2] = 1'b1;
        wr(2'd0, d, 2'b01);
      end else if (op < 62) begin
        if (!m_en)
          wr(2'd1, 16'($urandom_range(0, 3)), 2'($urandom_range(1, 3)));
      end else if (op < 68) begin
        wr(2'd3, d, 2'($urandom_range(1, 3)));
      end else if (op < 85) begin
        if ($urandom_range(0, 9) == 0)
          rd(14'h0054 | 14'($urandom_range(0, 3)), act, mod);
        else
          rd(WBASE | 14'($urandom_range(0, 3)), act, mod);
        check("rand read", 64'(act), 64'(mod));
      end else begin
        idle($urandom_range(1, 10));
      end
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
